device_b_receiver: RTL and testbench

//   Consumer side of the deviceA -> deviceB transfer. Captures each 64-bit word placed on sharedBus

---
 rtl/device_b_receiver.sv | 164 ++++++++++++++++
 tb/tb_device_b_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/device_b_receiver.sv
// rtl/device_b_receiver.sv - captures 64-bit words under a 4-phase handshake, buffers them and
// serialises each into LANES narrow beats on a valid/ready stream.
module device_b_receiver #(
    parameter int WORD_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clkB,
    input  logic                      reset,
    input  logic [WORD_W*LANES-1:0]   sharedBus,
    input  logic                      readyA,
    output logic                      acceptedB,
    output logic [WORD_W-1:0]         dataB,
    output logic                      validB,
    output logic                      lastB,
    input  logic                      readyB,
    output logic                      fullB,
    output logic [CNT_W-1:0]          countB
);
    localparam int BUS_W  = WORD_W * LANES;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [BUS_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic [LANE_W-1:0]  r_lane;
    logic               r_valid;
    logic               r_last;
    logic [WORD_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_push;
    logic               w_beat;
    logic               w_lane_end;
    logic               w_pop;
    logic               w_more;
    logic [PTR_W-1:0]   w_rd_ptr_inc;
    logic [LANE_W-1:0]  w_lane_inc;
    logic [WORD_W-1:0]  w_cur_lane [LANES];
    logic [WORD_W-1:0]  w_nxt_lane0;

    assign w_full       = (r_occ == OCC_W'(DEPTH));
    assign w_beat       = r_valid && readyB;
    assign w_lane_end   = (r_lane == LANE_W'(LANES - 1));
    assign w_pop        = w_beat && w_lane_end;
    assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
    assign w_lane_inc   = r_lane + LANE_W'(1);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_cur_lane[g] = r_mem[r_rd_ptr][g*WORD_W +: WORD_W];
        end
    endgenerate

    // Word following the head: either already buffered, or being captured on this very edge.
    assign w_more      = (r_occ >= OCC_W'(2)) || w_push;
    assign w_nxt_lane0 = (r_occ >= OCC_W'(2)) ? r_mem[w_rd_ptr_inc][WORD_W-1:0]
                                              : sharedBus[WORD_W-1:0];

    always_comb begin
        w_state_nx = r_state;
        w_push     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (readyA && !w_full) begin
                    w_push     = 1'b1;
                    w_state_nx = S_ACK;
                end
            end
            S_ACK: begin
                if (!readyA) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clkB or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_push) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clkB) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sharedBus;
        end
    end

    always_ff @(posedge clkB or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // The head word stays in the FIFO until its last lane leaves, so r_occ counts it.
    always_ff @(posedge clkB or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_lane  <= '0;
        end else if (w_beat) begin
            if (w_lane_end) begin
                r_lane <= '0;
                r_last <= (LANES == 1) && w_more;
                if (w_more) begin
                    r_valid <= 1'b1;
                    r_data  <= w_nxt_lane0;
                end else begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end
            end else begin
                r_lane <= w_lane_inc;
                r_data <= w_cur_lane[w_lane_inc];
                r_last <= (w_lane_inc == LANE_W'(LANES - 1));
            end
        end else if (!r_valid && (r_occ != '0)) begin
            r_valid <= 1'b1;
            r_data  <= w_cur_lane[0];
            r_lane  <= '0;
            r_last  <= (LANES == 1);
        end
    end

    assign acceptedB = (r_state == S_ACK);
    assign dataB     = r_data;
    assign validB    = r_valid;
    assign lastB     = r_last;
    assign fullB     = w_full;
    assign countB    = r_count;
endmodule

// File: tb/tb_device_b_receiver.sv
// tb/tb_device_b_receiver.sv - scoreboard bench for device_b_receiver.
module tb_device_b_receiver;
    logic        clkB = 1'b0;
    logic        reset;
    logic [63:0] sharedBus;
    logic        readyA;
    logic        acceptedB;
    logic [15:0] dataB;
    logic        validB;
    logic        lastB;
    logic        readyB;
    logic        fullB;
    logic [15:0] countB;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] sbq [$];
    logic        stalled = 1'b0;
    logic [15:0] st_data;
    logic        st_last;

    device_b_receiver dut (
        .clkB      (clkB),
        .reset     (reset),
        .sharedBus (sharedBus),
        .readyA    (readyA),
        .acceptedB (acceptedB),
        .dataB     (dataB),
        .validB    (validB),
        .lastB     (lastB),
        .readyB    (readyB),
        .fullB     (fullB),
        .countB    (countB)
    );

    always #5 clkB = ~clkB;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clkB);
        #1;
    endtask

    task automatic push_beats(input logic [63:0] w);
        for (int i = 0; i < 4; i++) begin
            sbq.push_back({(i == 3), w[i*16 +: 16]});
        end
    endtask

    // Word into a non-full receiver: acceptedB must rise on the first edge and fall one edge after readyA drops.
    task automatic send_now(input logic [63:0] w, input int hold);
        push_beats(w);
        sharedBus = w;
        readyA    = 1'b1;
        step();
        chk("acc_rise", acceptedB, 1);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("acc_hold", acceptedB, 1);
        end
        readyA = 1'b0;
        step();
        chk("acc_fall", acceptedB, 0);
    endtask

    task automatic drain();
        int k;
        readyB = 1'b1;
        k = 0;
        while ((sbq.size() != 0 || validB) && k < 300) begin
            step();
            k++;
        end
        chk("drain_done", {63'd0, (sbq.size() == 0 && !validB)}, 1);
    endtask

    // Monitor: compares each transferred beat against the queue and checks stability under stall.
    always @(negedge clkB) begin
        if (reset !== 1'b1) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", validB, 1);
                chk("stall_data", dataB, st_data);
                chk("stall_last", lastB, st_last);
            end
            if (validB && readyB) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", dataB, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = sbq.pop_front();
                    chk("beat_data", dataB, e[15:0]);
                    chk("beat_last", lastB, e[16]);
                end
            end
            stalled = validB && !readyB;
            st_data = dataB;
            st_last = lastB;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [63:0] wa, wb, wc;
        reset     = 1'b0;
        sharedBus = '0;
        readyA    = 1'b0;
        readyB    = 1'b0;
        repeat (3) step();
        chk("rst_acc", acceptedB, 0);
        chk("rst_valid", validB, 0);
        chk("rst_last", lastB, 0);
        chk("rst_data", dataB, 0);
        chk("rst_full", fullB, 0);
        chk("rst_count", countB, 0);
        reset = 1'b1;

        // 1: idle
        repeat (10) step();
        chk("idle_count", countB, 0);
        chk("idle_valid", validB, 0);

        // 2: single word
        readyB = 1'b1;
        send_now(64'h4444_3333_2222_1111, 0);
        chk("t2_count", countB, 1);
        drain();

        // 3: long readyA hold -> one capture
        send_now(64'hDEAD_BEEF_CAFE_F00D, 8);
        chk("t3_count_one", countB, 2);
        send_now(64'h0123_4567_89AB_CDEF, 0);
        chk("t3_count_two", countB, 3);
        drain();

        // 4: fill FIFO with sink stalled
        readyB = 1'b0;
        wa = 64'hA003_A002_A001_A000;
        wb = 64'hB003_B002_B001_B000;
        wc = 64'hC003_C002_C001_C000;
        push_beats(wa);
        sharedBus = wa; readyA = 1'b1;
        step();
        chk("t4_acc_a", acceptedB, 1);
        readyA = 1'b0;
        step();
        chk("t4_accfall_a", acceptedB, 0);
        push_beats(wb);
        sharedBus = wb; readyA = 1'b1;
        step();
        chk("t4_acc_b", acceptedB, 1);
        readyA = 1'b0;
        step();
        chk("t4_full", fullB, 1);
        push_beats(wc);
        sharedBus = wc; readyA = 1'b1;
        repeat (3) step();
        chk("t4_no_acc_c", acceptedB, 0);
        chk("t4_count_2", countB, 5);
        readyB = 1'b1;
        k = 0;
        while (!acceptedB && k < 20) begin
            step();
            k++;
        end
        chk("t4_acc_c_delay", k, 5);
        readyA = 1'b0;
        drain();
        chk("t4_count_3", countB, 6);

        // 5: sink stalls mid-word
        readyB = 1'b0;
        push_beats(64'h5D5D_5C5C_5B5B_5A5A);
        sharedBus = 64'h5D5D_5C5C_5B5B_5A5A; readyA = 1'b1;
        step();
        chk("t5_acc", acceptedB, 1);
        readyA = 1'b0;
        step();
        chk("t5_valid", validB, 1);
        begin
            logic [5:0] pat;
            pat = 6'b111_001;
            for (int i = 0; i < 6; i++) begin
                readyB = pat[i];
                step();
            end
        end
        drain();
        chk("t5_count", countB, 7);

        // 6: reset during serialisation
        readyB = 1'b0;
        push_beats(64'h6666_7777_8888_9999);
        sharedBus = 64'h6666_7777_8888_9999; readyA = 1'b1;
        step();
        readyA = 1'b0;
        step();
        chk("t6_valid", validB, 1);
        readyB = 1'b1;
        repeat (2) step();
        readyB = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", validB, 0);
        chk("t6_rst_data", dataB, 0);
        chk("t6_rst_last", lastB, 0);
        chk("t6_rst_count", countB, 0);
        chk("t6_rst_full", fullB, 0);
        sbq.delete();
        repeat (2) step();
        reset  = 1'b1;
        readyB = 1'b1;
        repeat (5) step();
        chk("t6_no_beats", validB, 0);
        send_now(64'h0F0F_0E0E_0D0D_0C0C, 0);
        chk("t6_count", countB, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
